// File: rtl/pat_field_buffer.sv
// rtl/pat_field_buffer.sv - ring of pattern buffers between byte streams and the pat core
// Optional core write-back port: define PATBUF_WRITEBACK_EN to build it.
module pat_field_buffer #(
    parameter int BUF_COUNT    = 8,
    parameter int BUFP_WIDTH   = 3,
    parameter int FIELD_COUNT  = 32,
    parameter int FIELDP_WIDTH = 5,
    parameter int FIELD_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FIELD_WIDTH-1:0]  in_data,
    input  logic                    in_last,
    input  logic [BUFP_WIDTH-1:0]   bufp,
    input  logic [FIELDP_WIDTH-1:0] fieldp,
    output logic [FIELD_WIDTH-1:0]  field_in,
    input  logic                    field_we,
    input  logic [FIELDP_WIDTH-1:0] fieldwp,
    input  logic [FIELD_WIDTH-1:0]  field_out,
    output logic                    proc_avail,
    input  logic                    proc_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FIELD_WIDTH-1:0]  out_data,
    output logic                    out_last
);

    localparam int DEPTH = BUF_COUNT * FIELD_COUNT;

    // Buffer life cycle; each transition belongs to exactly one agent
    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_FILLED = 2'd1;
    localparam logic [1:0] ST_PROC   = 2'd2;

    logic [1:0]              state [BUF_COUNT];
    logic [FIELDP_WIDTH:0]   len   [BUF_COUNT];
    logic [FIELD_WIDTH-1:0]  mem   [DEPTH];

    logic [BUFP_WIDTH-1:0]   fill_ptr;
    logic [BUFP_WIDTH-1:0]   proc_ptr;
    logic [BUFP_WIDTH-1:0]   drain_ptr;
    logic [FIELDP_WIDTH-1:0] fill_idx;
    logic [FIELDP_WIDTH-1:0] drain_idx;

    logic [BUFP_WIDTH-1:0]   eb;
    logic                    eb_filled;
    logic                    rd_ok;
    logic                    fill_fire;
    logic                    fill_end;
    logic                    proc_fire;
    logic                    drain_fire;
    logic                    drain_end;

    // Handshake and core-facing views; none depend on in_valid or out_ready
    always_comb begin
        eb         = proc_ptr + bufp;
        eb_filled  = (state[eb] == ST_FILLED);
        rd_ok      = eb_filled && ({1'b0, fieldp} < len[eb]);
        field_in   = rd_ok ? mem[{eb, fieldp}] : '0;
        in_ready   = (state[fill_ptr] == ST_EMPTY);
        proc_avail = (state[proc_ptr] == ST_FILLED);
        out_valid  = (state[drain_ptr] == ST_PROC);
        out_data   = mem[{drain_ptr, drain_idx}];
        out_last   = out_valid && ({1'b0, drain_idx} == (len[drain_ptr] - 1'b1));
    end

    // Per-agent transfer events
    always_comb begin
        fill_fire  = in_valid && in_ready;
        fill_end   = fill_fire && (in_last || (fill_idx == FIELDP_WIDTH'(FIELD_COUNT - 1)));
        proc_fire  = proc_done && proc_avail;
        drain_fire = out_valid && out_ready;
        drain_end  = drain_fire && out_last;
    end

`ifdef PATBUF_WRITEBACK_EN
    logic wr_ok;

    // Core write only lands inside the valid part of a FILLED buffer
    always_comb begin
        wr_ok = field_we && eb_filled && ({1'b0, fieldwp} < len[eb]);
    end

    // Buffer storage: stream fill port plus core write-back port
    always_ff @(posedge clk) begin
        if (fill_fire) begin
            mem[{fill_ptr, fill_idx}] <= in_data;
        end
        if (wr_ok) begin
            mem[{eb, fieldwp}] <= field_out;
        end
    end
`else
    wire unused_writeback = &{1'b0, field_we, fieldwp, field_out};

    // Buffer storage: stream fill port only
    always_ff @(posedge clk) begin
        if (fill_fire) begin
            mem[{fill_ptr, fill_idx}] <= in_data;
        end
    end
`endif

    // Ring pointers, indices, lengths and buffer states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_ptr  <= '0;
            proc_ptr  <= '0;
            drain_ptr <= '0;
            fill_idx  <= '0;
            drain_idx <= '0;
            for (int i = 0; i < BUF_COUNT; i++) begin
                state[i] <= ST_EMPTY;
                len[i]   <= '0;
            end
        end else begin
            if (fill_fire) begin
                if (fill_end) begin
                    state[fill_ptr] <= ST_FILLED;
                    len[fill_ptr]   <= {1'b0, fill_idx} + 1'b1;
                    fill_ptr        <= fill_ptr + 1'b1;
                    fill_idx        <= '0;
                end else begin
                    fill_idx <= fill_idx + 1'b1;
                end
            end
            if (proc_fire) begin
                state[proc_ptr] <= ST_PROC;
                proc_ptr        <= proc_ptr + 1'b1;
            end
            if (drain_fire) begin
                if (drain_end) begin
                    state[drain_ptr] <= ST_EMPTY;
                    drain_ptr        <= drain_ptr + 1'b1;
                    drain_idx        <= '0;
                end else begin
                    drain_idx <= drain_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pat_field_buffer.sv
// tb/tb_pat_field_buffer.sv - self-checking bench for pat_field_buffer
module tb_pat_field_buffer;

    localparam int NB = 8;
    localparam int NF = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic [2:0] bufp;
    logic [4:0] fieldp;
    logic [7:0] field_in;
    logic       field_we;
    logic [4:0] fieldwp;
    logic [7:0] field_out;
    logic       proc_avail;
    logic       proc_done;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pat_field_buffer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .bufp(bufp), .fieldp(fieldp), .field_in(field_in),
        .field_we(field_we), .fieldwp(fieldwp), .field_out(field_out),
        .proc_avail(proc_avail), .proc_done(proc_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    // Reference model: buffers tracked by running sequence counts of
    // completed fills (mf), releases (mp) and drains (md).
    int mdata [NB][NF];
    int mlen  [NB];
    int mf, mp, md, fcur, dcur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        mf = 0; mp = 0; md = 0; fcur = 0; dcur = 0;
        for (int i = 0; i < NB; i++) mlen[i] = 0;
    endtask

    function automatic bit m_filled(input int phys);
        int s;
        s = md + ((phys - (md % NB) + NB) % NB);
        return (s >= mp) && (s < mf);
    endfunction

    task automatic model_check();
        int eb, fi;
        eb = (mp + int'(bufp)) % NB;
        fi = (m_filled(eb) && int'(fieldp) < mlen[eb]) ? mdata[eb][fieldp] : 0;
        check("in_ready", in_ready, ((mf - md) < NB) ? 1 : 0);
        check("proc_avail", proc_avail, (mf > mp) ? 1 : 0);
        check("out_valid", out_valid, (mp > md) ? 1 : 0);
        check("field_in", field_in, fi);
        if (mp > md) begin
            check("out_data", out_data, mdata[md % NB][dcur]);
            check("out_last", out_last, (dcur == mlen[md % NB] - 1) ? 1 : 0);
        end else begin
            check("out_last_idle", out_last, 0);
        end
    endtask

    task automatic model_update();
        bit do_fill, do_proc, do_drain, do_wr;
        int eb;
        eb       = (mp + int'(bufp)) % NB;
        do_fill  = in_valid && ((mf - md) < NB);
        do_proc  = proc_done && (mf > mp);
        do_drain = out_ready && (mp > md);
        do_wr    = 1'b0;
`ifdef PATBUF_WRITEBACK_EN
        do_wr    = field_we && m_filled(eb) && (int'(fieldwp) < mlen[eb]);
`endif
        if (do_wr) mdata[eb][fieldwp] = int'(field_out);
        if (do_fill) begin
            mdata[mf % NB][fcur] = int'(in_data);
            if (in_last || fcur == NF - 1) begin
                mlen[mf % NB] = fcur + 1;
                mf++;
                fcur = 0;
            end else begin
                fcur++;
            end
        end
        if (do_proc) mp++;
        if (do_drain) begin
            if (dcur == mlen[md % NB] - 1) begin
                md++;
                dcur = 0;
            end else begin
                dcur++;
            end
        end
    endtask

    task automatic half_a();
        @(negedge clk);
        model_check();
    endtask

    task automatic half_b();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle();
        half_a();
        half_b();
    endtask

    task automatic idle();
        in_valid = 0; in_data = 0; in_last = 0; bufp = 0; fieldp = 0;
        field_we = 0; fieldwp = 0; field_out = 0; proc_done = 0; out_ready = 0;
    endtask

    // Asynchronous reset taken away from a clock edge, outputs checked at once
    task automatic do_reset(input string tag);
        idle();
        reset = 1'b1;
        m_reset();
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_proc_avail"}, proc_avail, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_field_in"}, field_in, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic last);
        in_valid = 1; in_data = d; in_last = last;
        cycle();
        in_valid = 0; in_last = 0;
    endtask

    typedef struct {
        logic       iv; logic [7:0] id; logic il;
        logic [2:0] bp; logic [4:0] fp;
        logic       we; logic [4:0] wp; logic [7:0] wd;
        logic       pd; logic ordy;
        logic       e_ir; logic e_pa; logic e_ov; logic [7:0] e_od; logic e_ol; logic [7:0] e_fi;
    } vec_t;

`ifdef PATBUF_WRITEBACK_EN
    localparam logic [7:0] WBV = 8'hA5;
`else
    localparam logic [7:0] WBV = 8'h22;
`endif

    vec_t tbl [15];

    initial begin
        reset = 1'b1;
        idle();
        m_reset();

        tbl[0]  = '{0, 8'h00, 0, 3'd0, 5'd0, 0, 5'd0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 8'h00};
        tbl[1]  = '{1, 8'h11, 0, 3'd0, 5'd0, 0, 5'd0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 8'h00};
        tbl[2]  = '{1, 8'h22, 0, 3'd0, 5'd0, 0, 5'd0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 8'h00};
        tbl[3]  = '{1, 8'h33, 1, 3'd0, 5'd0, 0, 5'd0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 8'h00};
        tbl[4]  = '{0, 8'h00, 0, 3'd0, 5'd0, 0, 5'd0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 8'h11};
        tbl[5]  = '{0, 8'h00, 0, 3'd0, 5'd1, 0, 5'd0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 8'h22};
        tbl[6]  = '{0, 8'h00, 0, 3'd0, 5'd2, 0, 5'd0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 8'h33};
        tbl[7]  = '{0, 8'h00, 0, 3'd0, 5'd3, 0, 5'd0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 8'h00};
        tbl[8]  = '{0, 8'h00, 0, 3'd1, 5'd0, 0, 5'd0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 8'h00};
        tbl[9]  = '{0, 8'h00, 0, 3'd0, 5'd1, 1, 5'd1, 8'hA5, 0, 0, 1, 1, 0, 8'h00, 0, 8'h22};
        tbl[10] = '{0, 8'h00, 0, 3'd0, 5'd1, 0, 5'd0, 8'h00, 1, 0, 1, 1, 0, 8'h00, 0, WBV};
        tbl[11] = '{0, 8'h00, 0, 3'd0, 5'd1, 0, 5'd0, 8'h00, 0, 1, 1, 0, 1, 8'h11, 0, 8'h00};
        tbl[12] = '{0, 8'h00, 0, 3'd0, 5'd1, 0, 5'd0, 8'h00, 0, 1, 1, 0, 1, WBV,   0, 8'h00};
        tbl[13] = '{0, 8'h00, 0, 3'd0, 5'd0, 0, 5'd0, 8'h00, 0, 1, 1, 0, 1, 8'h33, 1, 8'h00};
        tbl[14] = '{0, 8'h00, 0, 3'd0, 5'd0, 0, 5'd0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 8'h00};

        repeat (2) @(posedge clk);
        do_reset("rst0");

        // Directed vectors: short fill, reads, write-back, release, drain
        for (int i = 0; i < 15; i++) begin
            in_valid = tbl[i].iv; in_data = tbl[i].id; in_last = tbl[i].il;
            bufp = tbl[i].bp; fieldp = tbl[i].fp;
            field_we = tbl[i].we; fieldwp = tbl[i].wp; field_out = tbl[i].wd;
            proc_done = tbl[i].pd; out_ready = tbl[i].ordy;
            half_a();
            check($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ir);
            check($sformatf("vec%0d_proc_avail", i), proc_avail, tbl[i].e_pa);
            check($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
            check($sformatf("vec%0d_out_last", i), out_last, tbl[i].e_ol);
            check($sformatf("vec%0d_field_in", i), field_in, tbl[i].e_fi);
            if (tbl[i].e_ov) check($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_od);
            half_b();
        end
        idle();

        // Ring full: 8 x 32 beats with no release
        do_reset("rst1");
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < NF; i++)
                push(8'(b * NF + i), 1'b0);
        half_a();
        check("full_in_ready", in_ready, 0);
        half_b();
        proc_done = 1;
        cycle();
        proc_done = 0;
        out_ready = 1;
        repeat (NF) cycle();
        out_ready = 0;
        half_a();
        check("refill_in_ready", in_ready, 1);
        half_b();
        for (int i = 0; i < NF; i++) push(8'(8'hC0 + i), 1'b0);
        bufp = 3'd7; fieldp = 5'd5;
        half_a();
        check("ninth_in_phys0", field_in, 8'hC5);
        half_b();

        // Move the process pointer to 7, drain 1..6, then refill buffer 1
        idle();
        out_ready = 1;
        for (int k = 0; k < 193; k++) begin
            proc_done = (k < 6);
            cycle();
        end
        idle();
        half_a();
        check("wrap_out_valid", out_valid, 0);
        half_b();
        push(8'h71, 1'b0);
        push(8'h72, 1'b0);
        push(8'h73, 1'b1);
        bufp = 3'd2; fieldp = 5'd1;
        half_a();
        check("wrap_bufp2", field_in, 8'h72);
        half_b();
        bufp = 3'd0; fieldp = 5'd5;
        half_a();
        check("wrap_bufp0", field_in, 8'hE5);
        half_b();
        bufp = 3'd1;
        half_a();
        check("wrap_bufp1", field_in, 8'hC5);
        half_b();
        bufp = 3'd3;
        half_a();
        check("wrap_bufp3_empty", field_in, 8'h00);
        half_b();
        idle();

        // Release with nothing available, then an out_ready stall mid-drain
        do_reset("rst2");
        proc_done = 1;
        half_a();
        check("nop_release_pa", proc_avail, 0);
        half_b();
        proc_done = 0;
        half_a();
        check("nop_release_ov", out_valid, 0);
        half_b();
        push(8'h41, 1'b0); push(8'h42, 1'b0); push(8'h43, 1'b0); push(8'h44, 1'b1);
        half_a();
        check("after_nop_pa", proc_avail, 1);
        check("after_nop_fi", field_in, 8'h41);
        half_b();
        proc_done = 1;
        cycle();
        proc_done = 0;
        out_ready = 1;
        repeat (2) cycle();
        out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            half_a();
            check("stall_data", out_data, 8'h43);
            check("stall_last", out_last, 0);
            half_b();
        end
        out_ready = 1;
        half_a();
        check("resume_data0", out_data, 8'h43);
        half_b();
        half_a();
        check("resume_data1", out_data, 8'h44);
        check("resume_last1", out_last, 1);
        half_b();
        idle();

        // Reset during a drain and during a half-filled buffer
        push(8'h51, 1'b0); push(8'h52, 1'b0); push(8'h53, 1'b1);
        proc_done = 1;
        cycle();
        proc_done = 0;
        out_ready = 1;
        cycle();
        do_reset("rst_drain");
        for (int i = 0; i < 10; i++) push(8'(8'h60 + i), 1'b0);
        do_reset("rst_fill");
        push(8'h81, 1'b1);
        half_a();
        check("post_rst_fi", field_in, 8'h81);
        half_b();
        idle();

        // Randomized traffic under four rate mixes
        do_reset("rst3");
        for (int ph = 0; ph < 4; ph++) begin
            int piv, ppd, por;
            case (ph)
                0: begin piv = 90; ppd = 20; por = 20; end
                1: begin piv = 30; ppd = 80; por = 90; end
                2: begin piv = 70; ppd = 50; por = 50; end
                default: begin piv = 50; ppd = 90; por = 30; end
            endcase
            for (int k = 0; k < 600; k++) begin
                in_valid  = ($urandom_range(99) < piv);
                in_data   = 8'($urandom);
                in_last   = ($urandom_range(7) == 0);
                bufp      = ($urandom_range(3) == 0) ? 3'($urandom) : 3'd0;
                fieldp    = ($urandom_range(1) == 0) ? 5'($urandom_range(7)) : 5'($urandom);
                field_we  = ($urandom_range(2) == 0);
                fieldwp   = 5'($urandom_range(7));
                field_out = 8'($urandom);
                proc_done = ($urandom_range(99) < ppd);
                out_ready = ($urandom_range(99) < por);
                cycle();
            end
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pat_field_buffer.md
# pat_field_buffer

Ring of pattern buffers that sits directly around the `pat` core.
- An upstream byte stream fills whole buffers.
- The core reads and rewrites fields of the current buffer through its `bufp`/`fieldp`/`fieldwp`/`field_out` ports and releases it when done.
- Released buffers drain downstream as a byte stream in fill order.

Three ring pointers (fill, process, drain) and a per-buffer state give free-running double/multi-buffering between stream I/O and the core.

## Interface
Parameters:
- BUF_COUNT, 8, number of buffers (power of two)
- BUFP_WIDTH, 3, log2(BUF_COUNT); matches core `bufp`
- FIELD_COUNT, 32, fields per buffer (power of two)
- FIELDP_WIDTH, 5, log2(FIELD_COUNT); matches core `fieldp`
- FIELD_WIDTH, 8, field width; matches core `field_in`/`field_out`

Ports:
- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  upstream beat valid
- in_ready  out  1  upstream beat accepted this cycle if in_valid
- in_data  in  FIELD_WIDTH  upstream field value
- in_last  in  1  last beat of a buffer
- bufp  in  BUFP_WIDTH  core buffer offset relative to process pointer
- fieldp  in  FIELDP_WIDTH  core read field index
- field_in  out  FIELD_WIDTH  field value to core (combinational)
- field_we  in  1  core field write strobe
- fieldwp  in  FIELDP_WIDTH  core write field index
- field_out  in  FIELD_WIDTH  core write data
- proc_avail  out  1  buffer at process pointer is FILLED
- proc_done  in  1  core releases current buffer (pulse)
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts
- out_data  out  FIELD_WIDTH  drained field value
- out_last  out  1  last beat of a buffer

## Operation
- Per-buffer state: EMPTY → FILLED → PROCESSED → EMPTY. Each transition is owned by exactly one agent (fill, core, drain), so no two agents ever act on the same buffer.
- Per-buffer length `len`: FIELDP_WIDTH+1 bits, 1..FIELD_COUNT.
- **Fill.** `in_ready` = state[fill_ptr]==EMPTY. On each accepted beat:
  - Write `mem[fill_ptr][fill_idx] <= in_data` and increment `fill_idx`.
  - If `in_last` or `fill_idx==FIELD_COUNT-1`: `len <= fill_idx+1`, state FILLED, `fill_ptr++` (wraps mod BUF_COUNT), `fill_idx <= 0`.
- **Core.**
  - Effective buffer `eb = (proc_ptr + bufp) mod BUF_COUNT` (wrap-around lookahead).
  - `field_in = mem[eb][fieldp]` if state[eb]==FILLED and `fieldp < len[eb]`, else 0.
  - `field_we` writes `mem[eb][fieldwp] <= field_out` only if state[eb]==FILLED and `fieldwp < len[eb]`; otherwise the write is dropped.
  - `proc_done` with `proc_avail`=1: state[proc_ptr] PROCESSED, `proc_ptr++`. With `proc_avail`=0 it is ignored.
  - `field_we` and `proc_done` in the same cycle: the write lands, then the release takes effect.
- **Drain.**
  - `out_valid` = state[drain_ptr]==PROCESSED; `out_data = mem[drain_ptr][drain_idx]`; `out_last` = `drain_idx==len-1`.
  - On `out_valid & out_ready`: `drain_idx++`. On the last beat: state EMPTY, `drain_ptr++`, `drain_idx <= 0`.
- **Full/empty.**
  - Ring full: `in_ready`=0; upstream stalls and no data is lost.
  - Nothing FILLED: `proc_avail`=0.
  - Nothing PROCESSED: `out_valid`=0.

## Timing
- Reset values: all states EMPTY, all pointers and indices 0, all lengths 0. Memory contents are not reset.
- Outputs under reset: `in_ready`=1, `proc_avail`=0, `out_valid`=0, `out_last`=0, `out_data` don't-care-but-stable, `field_in`=0.
- Fill to core: the last beat accepted at edge N gives `proc_avail`=1 and readable fields from just after edge N.
- Core to drain: `proc_done` sampled at edge N gives `out_valid`=1 after edge N.
- Drain to fill: final drain beat at edge N makes the buffer EMPTY after edge N, so `in_ready` can return in that cycle.
- `field_in` is combinational from `bufp`/`fieldp`/state with zero latency, so the core can latch it at its next posedge. A core write at edge N is visible on `field_in` after edge N.
- `in_ready` and `out_valid` never depend combinationally on `in_valid` or `out_ready`.
- Reset asserted mid-operation: all buffers discarded immediately; in-flight beats are lost.

## Configuration
- `PATBUF_WRITEBACK_EN` defined: the core write port behaves as above.
- Undefined: `field_we`, `fieldwp` and `field_out` are ignored. Buffers drain byte-identical to their fill data, and no second write port is built.

## Test plan
- Reset, then stream 3 beats 0x11,0x22,0x33 with `in_last` on 0x33 → `proc_avail`=1 next cycle. `fieldp`=0..2 returns 0x11/0x22/0x33, `fieldp`=3 returns 0.
- With `PATBUF_WRITEBACK_EN`: write 0xA5 to `fieldwp`=1, then `proc_done`, then drain with `out_ready`=1 → out 0x11,0xA5,0x33 with `out_last` on the third beat.
- Fill 8 buffers of 32 beats with no `proc_done` → `in_ready`=0 after the 256th beat. Release 1 buffer and drain it → `in_ready` returns, and the 9th buffer writes physical buffer 0.
- `proc_ptr`=7, `bufp`=2 with buffers 7, 0 and 1 filled → `field_in` reads buffer 1 (wrap-around).
- `proc_done` while `proc_avail`=0 → no state change. `out_ready`=0 for 5 cycles mid-drain → `out_data` and `out_last` held stable.
- Assert reset during a half-filled buffer and during a drain → all outputs return to reset values immediately.
